// File: rtl/enthdr_ccc_tgt.sv
// I3C target-side ENTHDRx detector: matches the broadcast write header, ACKs it,
// then decodes the following CCC byte and T-bit against the supported HDR mode mask.
module enthdr_ccc_tgt #(
    parameter logic [6:0] BCAST_ADDR = 7'h7E,
    parameter logic [7:0] CCC_BASE   = 8'h20,
    parameter logic [7:0] MODE_MASK  = 8'h01,
    parameter bit         ACK_EN     = 1'b1
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_engine_en,
    input  logic       i_sda,
    input  logic       i_scl,
    input  logic       i_scl_pos_edge,
    input  logic       i_scl_neg_edge,
    output logic       o_sdahnd_sda,
    output logic       o_sda_oe,
    output logic       o_pp_od,
    output logic       o_engine_done,
    output logic [2:0] o_hdr_mode,
    output logic       o_parity_err,
    output logic       o_unsup_err,
    output logic       o_busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_ACK    = 3'd2;
    localparam logic [2:0] ST_CCC    = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;

    logic [2:0] state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] shreg, shreg_n;
    logic [1:0] ack_ph, ack_ph_n;
    logic       sda_q, scl_q;
    logic       oe_n, done_n, perr_n, uerr_n;
    logic [2:0] mode_n;
    logic       start_c, stop_c;
    logic [7:0] byte_in;

    assign start_c      = scl_q & i_scl & sda_q & ~i_sda;
    assign stop_c       = scl_q & i_scl & ~sda_q & i_sda;
    assign byte_in      = {shreg[6:0], i_sda};
    assign o_sdahnd_sda = 1'b0;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shreg_n  = shreg;
        ack_ph_n = ack_ph;
        oe_n     = o_sda_oe;
        done_n   = 1'b0;
        perr_n   = 1'b0;
        uerr_n   = 1'b0;
        mode_n   = o_hdr_mode;
        if (!i_engine_en) begin
            state_n  = ST_IDLE;
            cnt_n    = '0;
            ack_ph_n = '0;
            oe_n     = 1'b0;
        end else if (start_c) begin
            state_n  = ST_ADDR;
            cnt_n    = '0;
            ack_ph_n = '0;
            oe_n     = 1'b0;
        end else if (stop_c) begin
            state_n  = ST_IDLE;
            cnt_n    = '0;
            ack_ph_n = '0;
            oe_n     = 1'b0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_ADDR: if (i_scl_pos_edge) begin
                    shreg_n = byte_in;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        ack_ph_n = '0;
                        state_n  = (byte_in == {BCAST_ADDR, 1'b0}) ? ST_ACK : ST_IDLE;
                    end
                end
                // ack_ph: 0 = before ACK clock low, 1 = awaiting ACK sample, 2 = awaiting ACK clock fall
                ST_ACK: case (ack_ph)
                    2'd0: if (i_scl_neg_edge) begin
                        oe_n     = ACK_EN;
                        ack_ph_n = 2'd1;
                    end
                    2'd1: if (i_scl_pos_edge) begin
                        if (!ACK_EN && i_sda) state_n = ST_IDLE;
                        else                  ack_ph_n = 2'd2;
                    end
                    default: if (i_scl_neg_edge) begin
                        oe_n     = 1'b0;
                        cnt_n    = '0;
                        ack_ph_n = '0;
                        state_n  = ST_CCC;
                    end
                endcase
                ST_CCC: if (i_scl_pos_edge) begin
                    shreg_n = byte_in;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) state_n = ST_PARITY;
                end
                ST_PARITY: if (i_scl_pos_edge) begin
                    state_n = ST_IDLE;
                    if (shreg[7:3] == CCC_BASE[7:3]) begin
                        if (i_sda != ~^shreg)            perr_n = 1'b1;
                        else if (!MODE_MASK[shreg[2:0]]) uerr_n = 1'b1;
                        else begin
                            done_n = 1'b1;
                            mode_n = shreg[2:0];
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            shreg         <= '0;
            ack_ph        <= '0;
            sda_q         <= 1'b1;
            scl_q         <= 1'b1;
            o_sda_oe      <= 1'b0;
            o_pp_od       <= 1'b1;
            o_engine_done <= 1'b0;
            o_parity_err  <= 1'b0;
            o_unsup_err   <= 1'b0;
            o_hdr_mode    <= '0;
            o_busy        <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            shreg         <= shreg_n;
            ack_ph        <= ack_ph_n;
            sda_q         <= i_sda;
            scl_q         <= i_scl;
            o_sda_oe      <= oe_n;
            o_pp_od       <= ~oe_n;
            o_engine_done <= done_n;
            o_parity_err  <= perr_n;
            o_unsup_err   <= uerr_n;
            o_hdr_mode    <= mode_n;
            o_busy        <= (state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_enthdr_ccc_tgt.sv
// Scoreboarded bench for enthdr_ccc_tgt: directed I3C broadcast/CCC sequences push
// expected result pulses; a monitor pops and compares them as the DUT pulses.
module tb_enthdr_ccc_tgt;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       sda = 1'b1;
    logic       scl = 1'b1;
    logic       pos = 1'b0;
    logic       neg = 1'b0;
    logic       sdahnd_sda, sda_oe, pp_od, done, perr, uerr, busy;
    logic [2:0] hdr_mode;

    localparam logic [2:0] K_DONE = 3'b001;
    localparam logic [2:0] K_PERR = 3'b010;
    localparam logic [2:0] K_UERR = 3'b100;

    typedef struct {
        logic [2:0]  kind;
        logic [2:0]  mode;
        int unsigned stamp;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [2:0]  obs;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    enthdr_ccc_tgt #(
        .BCAST_ADDR(7'h7E),
        .CCC_BASE  (8'h20),
        .MODE_MASK (8'h05),
        .ACK_EN    (1'b1)
    ) dut (
        .i_sys_clk     (clk),
        .i_sys_rst     (rst_n),
        .i_engine_en   (en),
        .i_sda         (sda),
        .i_scl         (scl),
        .i_scl_pos_edge(pos),
        .i_scl_neg_edge(neg),
        .o_sdahnd_sda  (sdahnd_sda),
        .o_sda_oe      (sda_oe),
        .o_pp_od       (pp_od),
        .o_engine_done (done),
        .o_hdr_mode    (hdr_mode),
        .o_parity_err  (perr),
        .o_unsup_err   (uerr),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: result pulses are checked against the scoreboard, including their cycle.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            obs = {uerr, perr, done};
            if (sda_oe) begin
                chk("pp_od_while_oe", {31'd0, pp_od}, 32'd0);
                chk("sdahnd_sda", {31'd0, sdahnd_sda}, 32'd0);
            end
            if (obs != 3'b000) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got kind %b expected none (t=%0t)", obs, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("result_kind", {29'd0, obs}, {29'd0, e.kind});
                    chk("hdr_mode", {29'd0, hdr_mode}, {29'd0, e.mode});
                    chk("pulse_cycle", cyc, e.stamp);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rise(input logic [2:0] kind = 3'b000, input logic [2:0] mode = 3'd0);
        exp_t x;
        @(negedge clk);
        scl = 1'b1;
        pos = 1'b1;
        if (kind != 3'b000) begin
            x.kind  = kind;
            x.mode  = mode;
            x.stamp = cyc + 1;
            sbq.push_back(x);
        end
        @(negedge clk);
        pos = 1'b0;
    endtask

    task automatic fall();
        @(negedge clk);
        scl = 1'b0;
        neg = 1'b1;
        @(negedge clk);
        neg = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic [2:0] kind = 3'b000, input logic [2:0] mode = 3'd0);
        @(negedge clk);
        sda = b;
        tick();
        tick();
        rise(kind, mode);
        tick();
        tick();
        fall();
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    task automatic bus_start();
        @(negedge clk);
        sda = 1'b1;
        tick();
        if (!scl) begin
            rise();
            tick();
        end
        @(negedge clk);
        sda = 1'b0;
        tick();
        tick();
        fall();
        tick();
    endtask

    task automatic bus_stop();
        @(negedge clk);
        sda = 1'b0;
        tick();
        rise();
        tick();
        @(negedge clk);
        sda = 1'b1;
        tick();
        tick();
    endtask

    task automatic txn(input logic [7:0] hdr, input logic [7:0] code, input logic t,
                       input logic [2:0] kind, input logic [2:0] mode);
        bus_start();
        send_byte(hdr);
        if (hdr == 8'hFC) begin
            chk("oe_on_ack", {31'd0, sda_oe}, 32'd1);
            chk("busy_mid", {31'd0, busy}, 32'd1);
            send_bit(1'b0);
            chk("oe_after_ack", {31'd0, sda_oe}, 32'd0);
            send_byte(code);
            send_bit(t, kind, mode);
        end else begin
            chk("oe_bad_hdr", {31'd0, sda_oe}, 32'd0);
            chk("busy_bad_hdr", {31'd0, busy}, 32'd0);
        end
        bus_stop();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_pp_od", {31'd0, pp_od}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mode", {29'd0, hdr_mode}, 32'd0);
        chk("rst_pulses", {29'd0, uerr, perr, done}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        txn(8'hFC, 8'h20, 1'b0, K_DONE, 3'd0);
        txn(8'hFC, 8'h22, 1'b1, K_DONE, 3'd2);
        txn(8'hFC, 8'h21, 1'b1, K_UERR, 3'd2);
        txn(8'hFC, 8'h20, 1'b1, K_PERR, 3'd2);
        txn(8'hFC, 8'h06, 1'b1, 3'b000, 3'd0);
        txn(8'hFE, 8'h20, 1'b0, 3'b000, 3'd0);
        txn(8'hFD, 8'h20, 1'b0, 3'b000, 3'd0);

        // Repeated START in the middle of the CCC byte, then a clean ENTHDR0
        bus_start();
        send_byte(8'hFC);
        send_bit(1'b0);
        send_bits(8'h20, 4);
        txn(8'hFC, 8'h20, 1'b0, K_DONE, 3'd0);

        // STOP in the middle of the CCC byte
        bus_start();
        send_byte(8'hFC);
        send_bit(1'b0);
        send_bits(8'h20, 4);
        bus_stop();
        tick();
        chk("busy_after_stop", {31'd0, busy}, 32'd0);

        // Engine disable while the ACK is being driven; no result without a fresh START
        bus_start();
        send_byte(8'hFC);
        chk("oe_before_en_drop", {31'd0, sda_oe}, 32'd1);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("oe_en_drop", {31'd0, sda_oe}, 32'd0);
        chk("mode_kept_en_drop", {29'd0, hdr_mode}, 32'd0);
        en = 1'b1;
        send_bit(1'b0);
        send_byte(8'h20);
        send_bit(1'b0);
        bus_stop();

        txn(8'hFC, 8'h22, 1'b1, K_DONE, 3'd2);

        // Asynchronous reset while the ACK is being driven
        bus_start();
        send_byte(8'hFC);
        chk("oe_before_reset", {31'd0, sda_oe}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_oe", {31'd0, sda_oe}, 32'd0);
        chk("areset_pp_od", {31'd0, pp_od}, 32'd1);
        chk("areset_busy", {31'd0, busy}, 32'd0);
        chk("areset_mode", {29'd0, hdr_mode}, 32'd0);
        @(negedge clk);
        sda = 1'b1;
        scl = 1'b1;
        pos = 1'b0;
        neg = 1'b0;
        rst_n = 1'b1;

        repeat (10) tick();
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/enthdr_ccc_tgt.md
# enthdr_ccc_tgt

Parametrised I3C target-side HDR entry detector. It watches the SDR bus for a broadcast header (`BCAST_ADDR` + W), ACKs it, and receives the following CCC byte and its T-bit. It decodes any ENTHDRx command (`CCC_BASE` + x, x = 0..7) against a configurable supported-mode mask. It sits between the target SDA handler / SCL edge synchroniser and the target mode controller, which uses `o_hdr_mode` and `o_engine_done` to switch into the selected HDR engine.

## Interface
Parameters:
- `BCAST_ADDR`, 7'h7E: broadcast address matched in the header.
- `CCC_BASE`, 8'h20: code of ENTHDR0. ENTHDRx = `CCC_BASE` + x.
- `MODE_MASK`, 8'h01: bit x = 1 means HDR mode x is supported.
- `ACK_EN`, 1: 1 = target ACKs a matching header; 0 = passive, never drives SDA.

Ports:
- `i_sys_clk`, in, 1: system clock.
- `i_sys_rst`, in, 1: reset i_sys_rst, asynchronous, active-low; clock i_sys_clk.
- `i_engine_en`, in, 1: enables detection. Low forces IDLE and releases all outputs.
- `i_sda`, in, 1: synchronised SDA.
- `i_scl`, in, 1: synchronised SCL.
- `i_scl_pos_edge`, in, 1: one-cycle pulse on SCL rise.
- `i_scl_neg_edge`, in, 1: one-cycle pulse on SCL fall.
- `o_sdahnd_sda`, out, 1: SDA value to the SDA handler. Always 0 here.
- `o_sda_oe`, out, 1: 1 = drive `o_sdahnd_sda`; 0 = release (high-Z at pad).
- `o_pp_od`, out, 1: 0 = open-drain, forced while `o_sda_oe`=1. 1 otherwise.
- `o_engine_done`, out, 1: one-cycle pulse when a valid, supported ENTHDRx is received.
- `o_hdr_mode`, out, 3: x of the last accepted ENTHDRx. Holds until the next accept.
- `o_parity_err`, out, 1: one-cycle pulse on a T-bit mismatch for an ENTHDRx code.
- `o_unsup_err`, out, 1: one-cycle pulse for a valid ENTHDRx with `MODE_MASK[x]`=0.
- `o_busy`, out, 1: 1 in any state other than IDLE.

## Operation
- Bus condition detection uses registered `sda_q` and `scl_q`.
  - START / Repeated START: `scl_q & i_scl & sda_q & ~i_sda`.
  - STOP: `scl_q & i_scl & ~sda_q & i_sda`.
- States and transitions:
  - IDLE: on START, go to ADDR with bit counter = 0.
  - ADDR: shift `i_sda` MSB-first on each `i_scl_pos_edge`, 8 bits.
    - After bit 8, a byte equal to {`BCAST_ADDR`,0} goes to ACK.
    - Any other byte goes to IDLE, SDA untouched.
  - ACK: on the first `i_scl_neg_edge`, assert `o_sda_oe` (if `ACK_EN`).
    - Count one `i_scl_pos_edge` (the ACK bit).
    - On the following `i_scl_neg_edge`, deassert `o_sda_oe` and go to CCC with counter = 0.
    - With `ACK_EN`=0, the target never drives SDA. It still follows the bit and proceeds only if the sampled ACK bit = 0, else it goes to IDLE.
  - CCC: shift 8 bits MSB-first on `i_scl_pos_edge`, then go to PARITY.
  - PARITY: on `i_scl_pos_edge`, sample T and evaluate the result, then go to IDLE.
- Evaluation at the T-bit:
  - Let code = CCC byte.
  - is_enthdr = (code[7:3] == `CCC_BASE`[7:3]); x = code[2:0].
  - Expected T = `~^code` (odd parity).
  - Not is_enthdr: no pulse; IDLE.
  - is_enthdr and T mismatch: `o_parity_err` pulses.
  - is_enthdr, T ok, `MODE_MASK[x]`=0: `o_unsup_err` pulses.
  - is_enthdr, T ok, `MODE_MASK[x]`=1: `o_hdr_mode` ← x and `o_engine_done` pulses.
- Abort conditions:
  - Repeated START in any non-IDLE state: restart at ADDR with counter cleared and `o_sda_oe` released.
  - STOP in any non-IDLE state: go to IDLE, no pulses.
  - START detection takes priority over a coincident `i_scl_pos_edge` sample.
- `i_engine_en` low:
  - Next clock: IDLE, `o_sda_oe`=0, no pulses. `o_hdr_mode` is kept.
  - Rising again requires a fresh START.

## Timing
- Reset values:
  - state IDLE, counters 0, `sda_q`=1, `scl_q`=1.
  - `o_sda_oe`=0, `o_sdahnd_sda`=0, `o_pp_od`=1.
  - `o_engine_done`=0, `o_parity_err`=0, `o_unsup_err`=0, `o_busy`=0, `o_hdr_mode`=0.
- START is recognised 1 cycle after the SDA fall is seen; `o_busy` rises the cycle after that.
- `o_sda_oe` rises 1 cycle after the `i_scl_neg_edge` following address bit 8. It falls 1 cycle after the `i_scl_neg_edge` following the ACK bit.
- The result pulses (`o_engine_done` / `o_parity_err` / `o_unsup_err`) are registered.
  - They assert exactly 1 cycle after the T-bit `i_scl_pos_edge`, for exactly 1 cycle.
  - At most one of the three asserts per transaction.
- `o_hdr_mode` updates in the same cycle as `o_engine_done`.
- All outputs are registered; no combinational path from inputs.

## Test plan
- Broadcast 0x7E+W, ACK, code 0x20, T=0 → `o_sda_oe` high only across the ACK bit; `o_engine_done` one pulse; `o_hdr_mode`=0.
- `MODE_MASK`=8'h05, code 0x22, T=1 → done pulse, `o_hdr_mode`=2. Code 0x21 with correct T → `o_unsup_err` pulse, `o_hdr_mode` stays 2.
- Code 0x20 with T=1 (wrong) → `o_parity_err` pulse, no done. Code 0x06 (RSTDAA) → no pulse of any kind.
- Header 0x7F+W or 0x7E+R → `o_sda_oe` never asserts; return to IDLE after bit 8.
- Repeated START during CCC bit 4, then a clean 0x7E+W / 0x20 sequence → a single done pulse. STOP during CCC → IDLE, no pulses.
- `i_engine_en` dropped mid-ACK → `o_sda_oe`=0 next cycle. Async reset mid-transaction → all outputs at reset values immediately.
